// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and default geometry.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam logic [7:0] DEF_MAGIC  = 8'hA5;
    localparam int         DEF_ADDR_W = 12;

endpackage

// File: rtl/prog_loader_csum.sv
// Modulo-256 running byte sum used to validate a load frame.
module prog_loader_csum (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       add_en,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sum <= 8'h00;
        else if (clear)
            sum <= 8'h00;
        else if (add_en)
            sum <= sum + din;
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: MAGIC, 12-bit length, data bytes, optional checksum.
// Checksum byte and validation are present only when PROG_LOADER_CSUM_EN is defined.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] MAGIC  = DEF_MAGIC,
    parameter int         ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

`ifdef PROG_LOADER_CSUM_EN
    localparam state_t END_ST = CSUM;
`else
    localparam state_t END_ST = DONE;
`endif

    state_t            state, state_n;
    logic [3:0]        len_hi;
    logic [11:0]       remain;
    logic [ADDR_W-1:0] cnt;
    logic [11:0]       length;
    logic              accept;
    logic              wr;
    logic              remain_ld;
    logic              cnt_clr;

    // start always wins over a byte arriving in the same cycle
    assign accept = rx_valid && !start;
    assign length = {len_hi, rx_data};

`ifdef PROG_LOADER_CSUM_EN
    logic       csum_clr;
    logic       csum_add;
    logic [7:0] csum_sum;

    assign csum_clr = (state == IDLE);
    assign csum_add = accept && (state == LEN_HI || state == LEN_LO || state == DATA);

    prog_loader_csum u_csum (
        .clk    (clk),
        .reset  (reset),
        .clear  (csum_clr),
        .add_en (csum_add),
        .din    (rx_data),
        .sum    (csum_sum)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        wr        = 1'b0;
        remain_ld = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && rx_data == MAGIC)
                    state_n = LEN_HI;
            end
            LEN_HI: begin
                if (accept)
                    state_n = (rx_data[7:4] != 4'h0) ? ERR : LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    remain_ld = 1'b1;
                    cnt_clr   = 1'b1;
                    state_n   = (length == 12'd0) ? END_ST : DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    wr = 1'b1;
                    if (remain == 12'd1)
                        state_n = END_ST;
                end
            end
`ifdef PROG_LOADER_CSUM_EN
            CSUM: begin
                if (accept)
                    state_n = (rx_data == csum_sum) ? DONE : ERR;
            end
`endif
            DONE, ERR: begin
                if (start)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (start && state != DONE && state != ERR)
            state_n = IDLE;
    end

    // Write stage: the accepted byte appears on the memory port one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_hi    <= 4'h0;
            remain    <= 12'd0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            mem_we    <= 1'b0;
        end else begin
            mem_we <= wr;
            if (state == LEN_HI && accept)
                len_hi <= rx_data[3:0];
            if (remain_ld)
                remain <= length;
            else if (wr)
                remain <= remain - 12'd1;
            if (cnt_clr)
                cnt <= '0;
            else if (wr)
                cnt <= cnt + 1'b1;
            if (wr) begin
                mem_addr  <= cnt;
                mem_wdata <= rx_data;
            end
        end
    end

    assign cpu_hold  = (state != DONE);
    assign load_done = (state == DONE);
    assign load_err  = (state == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; frames carry a checksum byte when PROG_LOADER_CSUM_EN is defined.
module tb_prog_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        start;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (mem_we) wr_count++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_csum(input logic [7:0] b);
`ifdef PROG_LOADER_CSUM_EN
        send(b);
`else
        rx_data = b;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [2:0] flags();
        return {cpu_hold, load_done, load_err};
    endfunction

    initial begin
        int   base;
        int   bad;
        logic [7:0] sum;
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        start    = 1'b0;
        idle(2);
        chk("rst_flags", 32'(flags()), 32'(3'b100));
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        reset = 1'b0;
        idle(2);

        // Basic 3-byte frame, each write one cycle after its byte
        base = wr_count;
        send(8'hA5); send(8'h00); send(8'h03);
        send(8'h11);
        chk("a_w0", {mem_we, 3'b0, mem_addr, 8'h0, mem_wdata}, {1'b1, 3'b0, 12'd0, 8'h0, 8'h11});
        send(8'h22);
        chk("a_w1", {mem_we, 3'b0, mem_addr, 8'h0, mem_wdata}, {1'b1, 3'b0, 12'd1, 8'h0, 8'h22});
        send(8'h33);
        chk("a_w2", {mem_we, 3'b0, mem_addr, 8'h0, mem_wdata}, {1'b1, 3'b0, 12'd2, 8'h0, 8'h33});
        send_csum(8'h69);
        idle(2);
        chk("a_we_low", 32'(mem_we), 32'h0);
        chk("a_flags", 32'(flags()), 32'(3'b010));
        chk("a_wcount", wr_count - base, 3);
        send(8'hA5);
        chk("a_done_ignores", 32'(flags()), 32'(3'b010));
        pulse_start();
        chk("a_restart", 32'(flags()), 32'(3'b100));

`ifdef PROG_LOADER_CSUM_EN
        // Bad checksum
        send(8'hA5); send(8'h00); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33); send(8'h6A);
        idle(1);
        chk("bad_csum_flags", 32'(flags()), 32'(3'b101));
        pulse_start();
        chk("bad_csum_restart", 32'(flags()), 32'(3'b100));
`endif

        // Leading junk and gaps between bytes
        base = wr_count;
        send(8'h00); idle(3); send(8'hFF); idle(2);
        send(8'hA5); idle(4); send(8'h00); idle(1); send(8'h01); idle(5);
        send(8'h7E);
        chk("junk_w0", {mem_we, 3'b0, mem_addr, 8'h0, mem_wdata}, {1'b1, 3'b0, 12'd0, 8'h0, 8'h7E});
        idle(3);
        send_csum(8'h7F);
        idle(1);
        chk("junk_flags", 32'(flags()), 32'(3'b010));
        chk("junk_wcount", wr_count - base, 1);
        pulse_start();

        // Nonzero upper length nibble
        base = wr_count;
        send(8'hA5); send(8'h10);
        chk("lenhi_err", 32'(flags()), 32'(3'b101));
        send(8'h55); idle(2);
        chk("lenhi_nowrite", wr_count - base, 0);
        pulse_start();
        chk("lenhi_restart", 32'(flags()), 32'(3'b100));

        // Reset in the middle of a frame, with a write pending
        send(8'hA5); send(8'h00); send(8'h03);
        send(8'h11); send(8'h22);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_we", 32'(mem_we), 32'h0);
        chk("mid_rst_flags", 32'(flags()), 32'(3'b100));
        chk("mid_rst_addr", {20'h0, mem_addr, mem_wdata}, 32'h0);
        idle(3);
        reset = 1'b0;
        base = wr_count;
        send(8'h33); idle(2);
        chk("mid_rst_nowrite", wr_count - base, 0);
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'hAB);
        chk("fresh_w0", {mem_we, 3'b0, mem_addr, 8'h0, mem_wdata}, {1'b1, 3'b0, 12'd0, 8'h0, 8'hAB});
        send(8'hCD);
        chk("fresh_w1", {mem_we, 3'b0, mem_addr, 8'h0, mem_wdata}, {1'b1, 3'b0, 12'd1, 8'h0, 8'hCD});
        send_csum(8'h7A);
        idle(1);
        chk("fresh_flags", 32'(flags()), 32'(3'b010));
        chk("fresh_wcount", wr_count - base, 2);
        pulse_start();

        // Zero-length frame
        base = wr_count;
        send(8'hA5); send(8'h00); send(8'h00);
        send_csum(8'h00);
        idle(2);
        chk("zero_flags", 32'(flags()), 32'(3'b010));
        chk("zero_wcount", wr_count - base, 0);
        pulse_start();

        // start colliding with a data byte aborts without writing it
        base = wr_count;
        send(8'hA5); send(8'h00); send(8'h02);
        @(negedge clk);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
        chk("abort_we", 32'(mem_we), 32'h0);
        chk("abort_flags", 32'(flags()), 32'(3'b100));
        send(8'h66); idle(2);
        chk("abort_wcount", wr_count - base, 0);

        // Maximum length frame: addresses 0..4094
        base = wr_count;
        bad  = 0;
        sum  = 8'h0F + 8'hFF;
        send(8'hA5); send(8'h0F); send(8'hFF);
        for (int i = 0; i < 4095; i++) begin
            send(8'(i));
            sum = sum + 8'(i);
            if (!mem_we || mem_addr != 12'(i) || mem_wdata != 8'(i)) bad++;
        end
        chk("max_last_addr", 32'(mem_addr), 32'd4094);
        chk("max_seq_bad", bad, 0);
        send_csum(sum);
        idle(2);
        chk("max_flags", 32'(flags()), 32'(3'b010));
        chk("max_wcount", wr_count - base, 4095);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
